// File: rtl/peripheral_msi_slave_arbiter_bb.sv
// Per-slave-port arbiter for the MSI AHB-Lite interconnect: priority plus round-robin, AHB-legal handover.
// Optional hold-budget preemption is compiled in with `define PERIPHERAL_MSI_ARB_TIMEOUT_EN.
module peripheral_msi_slave_arbiter_bb #(
  parameter int MASTERS  = 5,
  parameter int HOLD_MAX = 16
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic [MASTERS*3-1:0]       mstpriority,
  input  logic [MASTERS-1:0]         mstHSEL,
  input  logic [MASTERS*2-1:0]       mstHTRANS,
  input  logic [MASTERS-1:0]         mstHMASTLOCK,
  input  logic [MASTERS-1:0]         can_switch,
  input  logic                       slv_HREADY,
  output logic [MASTERS-1:0]         granted_master,
  output logic [$clog2(MASTERS)-1:0] grant_idx,
  output logic                       grant_valid,
  output logic                       grant_locked
);

  localparam int IDX_W = $clog2(MASTERS);
  localparam logic [IDX_W:0]   MASTERS_W = (IDX_W+1)'(MASTERS);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(MASTERS-1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWNED,
    ST_LOCKED
  } state_t;

  state_t             state_reg;
  logic [MASTERS-1:0] granted_reg;
  logic [IDX_W-1:0]   owner_reg;
  logic [IDX_W-1:0]   last_idx_reg;
  logic               valid_reg;
  logic               locked_reg;

  logic [MASTERS-1:0] req;
  logic [2:0]         prio [MASTERS];
  logic [MASTERS-1:0] unused_htrans_lsb;

  genvar gi;
  generate
    for (gi = 0; gi < MASTERS; gi++) begin : g_port
      assign req[gi]               = mstHSEL[gi] & mstHTRANS[2*gi+1];
      assign prio[gi]              = mstpriority[3*gi +: 3];
      assign unused_htrans_lsb[gi] = mstHTRANS[2*gi];
    end
  endgenerate

  // Winner: highest priority, ties resolved by the first requester after last_idx.
  // The current owner is always last_idx, so it is naturally last in any tie.
  logic [2:0]       max_prio;
  logic [IDX_W:0]   scan_pos;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;

  always_comb begin
    max_prio = '0;
    for (int m = 0; m < MASTERS; m++) begin
      if (req[m] && (prio[m] > max_prio)) begin
        max_prio = prio[m];
      end
    end
    win_found = 1'b0;
    win_idx   = '0;
    scan_pos  = '0;
    scan_idx  = '0;
    for (int k = 1; k <= MASTERS; k++) begin
      scan_pos = {1'b0, last_idx_reg} + (IDX_W+1)'(k);
      if (scan_pos >= MASTERS_W) begin
        scan_pos = scan_pos - MASTERS_W;
      end
      scan_idx = scan_pos[IDX_W-1:0];
      if (!win_found && req[scan_idx] && (prio[scan_idx] == max_prio)) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  logic own_req;
  logic own_lock;
  logic own_cs;
  logic others_req;
  logic force_switch;
  logic switch_pt;

  assign own_req    = req[owner_reg];
  assign own_lock   = mstHMASTLOCK[owner_reg];
  assign own_cs     = can_switch[owner_reg];
  assign others_req = |(req & ~granted_reg);

`ifdef PERIPHERAL_MSI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX+1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  logic [CNT_W-1:0] hold_cnt_reg;

  assign force_switch = (hold_cnt_reg == HOLD_LIM) & others_req;
`else
  localparam int UNUSED_HOLD_MAX = HOLD_MAX;
  logic unused_others_req;

  assign unused_others_req = others_req;
  assign force_switch      = 1'b0;
`endif

  assign switch_pt = own_cs | ~own_req | force_switch;

  // eval_beat: owner is not (or no longer) locked, so a handover may be considered.
  logic eval_beat;
  logic do_lock;
  logic do_grant;
  logic do_drop;

  assign do_lock   = (state_reg == ST_OWNED) & own_lock & own_req;
  assign eval_beat = ((state_reg == ST_OWNED) & ~(own_lock & own_req)) |
                     ((state_reg == ST_LOCKED) & ~own_lock);
  assign do_grant  = ((state_reg == ST_IDLE) & win_found) |
                     (eval_beat & switch_pt & win_found);
  assign do_drop   = eval_beat & switch_pt & ~win_found;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_reg    <= ST_IDLE;
      granted_reg  <= '0;
      owner_reg    <= '0;
      last_idx_reg <= LAST_RST;
      valid_reg    <= 1'b0;
      locked_reg   <= 1'b0;
    end else if (slv_HREADY) begin
      if (do_grant) begin
        state_reg    <= ST_OWNED;
        granted_reg  <= MASTERS'(1) << win_idx;
        owner_reg    <= win_idx;
        last_idx_reg <= win_idx;
        valid_reg    <= 1'b1;
        locked_reg   <= 1'b0;
      end else if (do_drop) begin
        state_reg   <= ST_IDLE;
        granted_reg <= '0;
        owner_reg   <= '0;
        valid_reg   <= 1'b0;
        locked_reg  <= 1'b0;
      end else if (do_lock) begin
        state_reg  <= ST_LOCKED;
        locked_reg <= 1'b1;
      end else if (eval_beat) begin
        state_reg  <= ST_OWNED;
        locked_reg <= 1'b0;
      end
    end
  end

`ifdef PERIPHERAL_MSI_ARB_TIMEOUT_EN
  // Counts unlocked ownership beats; saturates so the preemption request stays pending.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      hold_cnt_reg <= '0;
    end else if (slv_HREADY) begin
      if (do_grant || do_drop) begin
        hold_cnt_reg <= '0;
      end else if ((state_reg == ST_OWNED) && (hold_cnt_reg != HOLD_LIM)) begin
        hold_cnt_reg <= hold_cnt_reg + 1'b1;
      end
    end
  end
`endif

  assign granted_master = granted_reg;
  assign grant_idx      = owner_reg;
  assign grant_valid    = valid_reg;
  assign grant_locked   = locked_reg;

endmodule
